stack_cache_spill_fill_controller: RTL and testbench
====================================================

# stack_cache_spill_fill_controller

Sequences whole-line transfers between the stack cache line storage and the memory port whenever the stack pointer crosses a line boundary. A spill writes a line out on push-out; a fill reads a line back on pop-out. The block sits between the stack pointer tracking logic (the source of spill/fill requests and line addresses), the cache data array (word read/write port) and the memory request/response channel. It stalls the stack pipeline until the transfer completes.

## Interface
- LINESIZE, 8, words per line; power of two, ≥2
- DATABITWIDTH, 32, word width
- ADDRESS_BITWIDTH, 32, word-address width
- clk  in  1  single clock, all logic on posedge
- sync_rst  in  1  synchronous, active-high reset
- clk_en  in  1  global enable; when low all state and outputs hold
- SpillRequest  in  1  level; line must be written out (push-out)
- FillRequest  in  1  level; line must be read in (pop-out)
- LineAddress  in  ADDRESS_BITWIDTH  word address in line; low $clog2(LINESIZE) bits ignored
- StallOut  out  1  stack pipeline must hold push/pop
- Busy  out  1  state ≠ IDLE
- CacheWordIndex  out  $clog2(LINESIZE)  word index into line storage
- CacheReadEn  out  1  combinational read of CacheReadData this cycle
- CacheReadData  in  DATABITWIDTH  same-cycle read data
- CacheWriteEn  out  1  write CacheWriteData at CacheWordIndex this edge
- CacheWriteData  out  DATABITWIDTH  fill word
- MemReqValid  out  1  request valid
- MemReqReady  in  1  request accepted when Valid&&Ready at edge with clk_en
- MemReqWrite  out  1  1 = write (spill), 0 = read (fill)
- MemReqAddr  out  ADDRESS_BITWIDTH  word address
- MemReqData  out  DATABITWIDTH  write data
- MemRespValid  in  1  read response valid (one cycle)
- MemRespData  in  DATABITWIDTH  read response data
- SpillDonePulse, FillDonePulse  out  1 each  one-cycle completion pulses

## Operation
- States: IDLE, SPILL, FILL_REQ, FILL_WAIT, DONE. Registers: State, BaseAddr (LineAddress with low bits zeroed), WordIndex, IsSpill.
- IDLE: if SpillRequest, go to SPILL (spill wins if both are asserted). Otherwise if FillRequest, go to FILL_REQ. Either way, latch BaseAddr and set WordIndex = 0.
- SPILL: MemReqValid = 1, MemReqWrite = 1, CacheReadEn = 1, MemReqData = CacheReadData, MemReqAddr = BaseAddr + WordIndex.
  - On handshake: WordIndex++.
  - Handshake at WordIndex = LINESIZE-1 goes to DONE.
- FILL_REQ: MemReqValid = 1, MemReqWrite = 0, same address. On handshake, go to FILL_WAIT.
- FILL_WAIT: on MemRespValid, CacheWriteEn = 1, CacheWriteData = MemRespData.
  - After the write: WordIndex++ and return to FILL_REQ.
  - At the last index, go to DONE instead.
  - MemRespValid in any other state is ignored.
- DONE: SpillDonePulse = IsSpill, FillDonePulse = ~IsSpill. Return to IDLE next cycle; requests are not sampled in DONE.
- StallOut = (State ≠ IDLE) || (State == IDLE && (SpillRequest || FillRequest)).
- CacheWordIndex = WordIndex in every state.
- All address arithmetic is modulo 2^ADDRESS_BITWIDTH. WordIndex wraps to 0 on leaving the last word.
- MemReqValid, once asserted, stays asserted with stable Addr/Data/Write until handshake. This includes cycles where clk_en is low.

## Timing
- Reset: State = IDLE, WordIndex = 0, BaseAddr = 0, IsSpill = 0.
  - Outputs at reset: MemReqValid = 0, CacheReadEn = 0, CacheWriteEn = 0, Busy = 0, both pulses = 0.
  - StallOut follows the requests combinationally.
- Reset mid-transfer aborts to IDLE at that edge. Later MemRespValid is ignored, and no done pulse is issued.
- Request seen in IDLE at edge N: first MemReqValid in cycle N+1.
- Spill with MemReqReady tied high: LINESIZE cycles in SPILL, DONE at N+1+LINESIZE, Busy low at N+2+LINESIZE.
- Fill with Ready high and response one cycle after acceptance: 2 cycles per word; DONE at N+1+2·LINESIZE.
- Response in the same cycle as entry to FILL_WAIT is not possible. A response is only taken the cycle after acceptance or later.
- clk_en low: no state change, no handshake counted, and CacheWriteEn is suppressed.

## Structure
- Shared package stack_cache_pkg holds:
  - the state enum (IDLE, SPILL, FILL_REQ, FILL_WAIT, DONE);
  - the LINEADDRBITWIDTH = (LINESIZE == 1) ? 1 : $clog2(LINESIZE) constant function.
- One sub-module, stack_cache_line_word_counter, implements WordIndex:
  - inputs: clear, increment, clk_en;
  - outputs: index and IsLast flag.
- The FSM and output decode stay in the top module.

## Test plan
- Spill, LINESIZE = 8, Ready always 1, LineAddress = 0x0000_1005:
  - expect 8 writes to 0x1000..0x1007 carrying cache words 0..7;
  - expect SpillDonePulse 9 cycles after the request edge;
  - expect StallOut high throughout.
- Fill, LineAddress = 0x2000, response data = 0xA0+i one cycle after each acceptance:
  - expect 8 reads to 0x2000..0x2007;
  - expect CacheWriteEn at index i with data 0xA0+i;
  - expect FillDonePulse at cycle 17.
- Backpressure: Ready low for 3 cycles on word 2 of a spill → Valid, Addr 0x1002 and Data stay stable; the word is counted once.
- Simultaneous SpillRequest and FillRequest in IDLE → spill runs first. After DONE, with FillRequest still high, the fill starts.
- sync_rst asserted in FILL_WAIT at word 4 → IDLE next cycle. A late MemRespValid causes no cache write, and no done pulse is seen.
- clk_en low for 2 cycles mid-spill and during a pending response → state, index and outputs frozen. The transfer completes with a correct word count.

Source files
------------

// File: rtl/stack_cache_pkg.sv
// Shared types and helpers for the stack cache spill/fill controller.
package stack_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPILL     = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_WAIT = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  function automatic int unsigned line_addr_bitwidth(input int unsigned linesize);
    return (linesize == 1) ? 1 : $clog2(linesize);
  endfunction

endpackage

// File: rtl/stack_cache_line_word_counter.sv
// Word index within the line being transferred; wraps naturally past the last word.
module stack_cache_line_word_counter
  import stack_cache_pkg::*;
#(
  parameter int unsigned LINESIZE = 8,
  parameter int unsigned IW       = line_addr_bitwidth(LINESIZE)
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic          clk_en,
  input  logic          clear_i,
  input  logic          increment_i,
  output logic [IW-1:0] index_o,
  output logic          is_last_o
);

  logic [IW-1:0] index_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      index_q <= '0;
    end else if (clk_en) begin
      if (clear_i) begin
        index_q <= '0;
      end else if (increment_i) begin
        index_q <= index_q + IW'(1);
      end
    end
  end

  assign index_o   = index_q;
  assign is_last_o = (index_q == IW'(LINESIZE - 1));

endmodule

// File: rtl/stack_cache_spill_fill_controller.sv
// Sequences whole-line spills (cache -> memory) and fills (memory -> cache)
// and stalls the stack pipeline while a transfer is in flight.
module stack_cache_spill_fill_controller
  import stack_cache_pkg::*;
#(
  parameter int unsigned LINESIZE         = 8,
  parameter int unsigned DATABITWIDTH     = 32,
  parameter int unsigned ADDRESS_BITWIDTH = 32,
  localparam int unsigned IW              = line_addr_bitwidth(LINESIZE)
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        clk_en,
  input  logic                        SpillRequest,
  input  logic                        FillRequest,
  input  logic [ADDRESS_BITWIDTH-1:0] LineAddress,
  output logic                        StallOut,
  output logic                        Busy,
  output logic [IW-1:0]               CacheWordIndex,
  output logic                        CacheReadEn,
  input  logic [DATABITWIDTH-1:0]     CacheReadData,
  output logic                        CacheWriteEn,
  output logic [DATABITWIDTH-1:0]     CacheWriteData,
  output logic                        MemReqValid,
  input  logic                        MemReqReady,
  output logic                        MemReqWrite,
  output logic [ADDRESS_BITWIDTH-1:0] MemReqAddr,
  output logic [DATABITWIDTH-1:0]     MemReqData,
  input  logic                        MemRespValid,
  input  logic [DATABITWIDTH-1:0]     MemRespData,
  output logic                        SpillDonePulse,
  output logic                        FillDonePulse
);

  state_e                      state_q, state_d;
  logic [ADDRESS_BITWIDTH-1:0] base_q, base_d;
  logic                        is_spill_q, is_spill_d;
  logic                        cnt_clear, cnt_inc, cnt_last;
  logic [IW-1:0]               word_index;

  stack_cache_line_word_counter #(
    .LINESIZE (LINESIZE),
    .IW       (IW)
  ) u_word_counter (
    .clk         (clk),
    .sync_rst    (sync_rst),
    .clk_en      (clk_en),
    .clear_i     (cnt_clear),
    .increment_i (cnt_inc),
    .index_o     (word_index),
    .is_last_o   (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      is_spill_q <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      base_q     <= base_d;
      is_spill_q <= is_spill_d;
    end
  end

  // Next-state logic; the counter only moves on accepted words.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    is_spill_d = is_spill_q;
    cnt_clear  = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (SpillRequest) begin
          state_d    = ST_SPILL;
          base_d     = LineAddress & ~ADDRESS_BITWIDTH'(LINESIZE - 1);
          is_spill_d = 1'b1;
        end else if (FillRequest) begin
          state_d    = ST_FILL_REQ;
          base_d     = LineAddress & ~ADDRESS_BITWIDTH'(LINESIZE - 1);
          is_spill_d = 1'b0;
        end
      end
      ST_SPILL: begin
        if (MemReqReady) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FILL_REQ: begin
        if (MemReqReady) begin
          state_d = ST_FILL_WAIT;
        end
      end
      ST_FILL_WAIT: begin
        if (MemRespValid) begin
          cnt_inc = 1'b1;
          state_d = cnt_last ? ST_DONE : ST_FILL_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode straight from the state register.
  always_comb begin
    MemReqValid    = 1'b0;
    MemReqWrite    = 1'b0;
    MemReqData     = '0;
    CacheReadEn    = 1'b0;
    CacheWriteEn   = 1'b0;
    CacheWriteData = '0;
    SpillDonePulse = 1'b0;
    FillDonePulse  = 1'b0;
    case (state_q)
      ST_SPILL: begin
        MemReqValid = 1'b1;
        MemReqWrite = 1'b1;
        CacheReadEn = 1'b1;
        MemReqData  = CacheReadData;
      end
      ST_FILL_REQ: MemReqValid = 1'b1;
      ST_FILL_WAIT: begin
        if (MemRespValid && clk_en) begin
          CacheWriteEn   = 1'b1;
          CacheWriteData = MemRespData;
        end
      end
      ST_DONE: begin
        SpillDonePulse = is_spill_q;
        FillDonePulse  = ~is_spill_q;
      end
      default: ;
    endcase
  end

  assign MemReqAddr     = base_q + ADDRESS_BITWIDTH'(word_index);
  assign CacheWordIndex = word_index;
  assign Busy           = (state_q != ST_IDLE);
  assign StallOut       = Busy || SpillRequest || FillRequest;

endmodule

// File: tb/tb_stack_cache_spill_fill_controller.sv
// Directed bench: transaction-level expectation queues plus hand-pinned literals.
module tb_stack_cache_spill_fill_controller;

  logic        clk = 1'b0;
  logic        sync_rst, clk_en, SpillRequest, FillRequest;
  logic [31:0] LineAddress;
  logic        StallOut, Busy, CacheReadEn, CacheWriteEn;
  logic [2:0]  CacheWordIndex;
  logic [31:0] CacheReadData, CacheWriteData, MemReqAddr, MemReqData;
  logic        MemReqValid, MemReqReady, MemReqWrite;
  logic        MemRespValid = 1'b0;
  logic [31:0] MemRespData  = 32'h0;
  logic        SpillDonePulse, FillDonePulse;

  stack_cache_spill_fill_controller #(
    .LINESIZE(8), .DATABITWIDTH(32), .ADDRESS_BITWIDTH(32)
  ) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en),
    .SpillRequest(SpillRequest), .FillRequest(FillRequest), .LineAddress(LineAddress),
    .StallOut(StallOut), .Busy(Busy), .CacheWordIndex(CacheWordIndex),
    .CacheReadEn(CacheReadEn), .CacheReadData(CacheReadData),
    .CacheWriteEn(CacheWriteEn), .CacheWriteData(CacheWriteData),
    .MemReqValid(MemReqValid), .MemReqReady(MemReqReady), .MemReqWrite(MemReqWrite),
    .MemReqAddr(MemReqAddr), .MemReqData(MemReqData),
    .MemRespValid(MemRespValid), .MemRespData(MemRespData),
    .SpillDonePulse(SpillDonePulse), .FillDonePulse(FillDonePulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] cache_mem [8];
  assign CacheReadData = cache_mem[CacheWordIndex];

  typedef struct packed {logic wr; logic [31:0] addr; logic [31:0] data;} req_t;
  typedef struct packed {logic [2:0] idx; logic [31:0] data;} cw_t;
  req_t req_q[$];
  cw_t  cw_q[$];
  bit   done_q[$];

  int compared = 0, mismatched = 0;
  int unsigned done_cnt = 0, done_cyc = 0, acc_cnt = 0, resp_cnt = 0, stall_low = 0;
  logic [31:0] acc_addr = 32'h0, first_hs_addr = 32'h0;
  bit first_hs_seen = 0, resp_en = 1, last_done_spill = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_spill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) req_q.push_back('{1'b1, base + 32'(i), cache_mem[i]});
    done_q.push_back(1'b1);
  endtask

  task automatic expect_fill(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      req_q.push_back('{1'b0, base + 32'(i), 32'h0});
      cw_q.push_back('{3'(i), 32'hA0 + 32'(i)});
    end
    done_q.push_back(1'b0);
  endtask

  task automatic wait_done(input int unsigned target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk); #1;
      n++;
      if (!StallOut) stall_low++;
    end
    if (done_cnt < target) check("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_req_idx(input logic wr, input logic [2:0] idx);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(MemReqValid && MemReqWrite == wr && CacheWordIndex == idx) && n < 60);
    check("req_idx_timeout", 32'(MemReqValid && CacheWordIndex == idx), 32'd1);
  endtask

  // Memory responder: one read response per accepted read, gated by clk_en/resp_en.
  always begin
    @(posedge clk); #2;
    if (acc_cnt != resp_cnt && resp_en && clk_en) begin
      MemRespValid = 1'b1;
      MemRespData  = 32'hA0 + 32'(acc_addr[2:0]);
      resp_cnt++;
    end else begin
      MemRespValid = 1'b0;
    end
  end

  // Compare process: protocol rules plus expectation queues, every cycle.
  logic        p_pend = 0, p_frz = 0, p_wr = 0, p_busy = 0, p_valid = 0;
  logic [31:0] p_addr = 0, p_data = 0;
  logic [2:0]  p_idx = 0;
  always @(negedge clk) begin : mon
    logic hs;
    req_t r;
    cw_t  w;
    bit   d;
    if (sync_rst) begin
      p_pend = 0;
      p_frz  = 0;
    end else begin
      hs = MemReqValid && MemReqReady && clk_en;
      check("stall_rule", 32'(StallOut), 32'(Busy || SpillRequest || FillRequest));
      check("readen_rule", 32'(CacheReadEn), 32'(MemReqValid && MemReqWrite));
      if (!clk_en) check("wen_gated", 32'(CacheWriteEn), 32'd0);
      if (p_pend) begin
        check("valid_hold", 32'(MemReqValid), 32'd1);
        check("addr_hold", MemReqAddr, p_addr);
        check("write_hold", 32'(MemReqWrite), 32'(p_wr));
        if (p_wr) check("data_hold", MemReqData, p_data);
      end
      if (p_frz) begin
        check("frz_busy", 32'(Busy), 32'(p_busy));
        check("frz_idx", 32'(CacheWordIndex), 32'(p_idx));
        check("frz_valid", 32'(MemReqValid), 32'(p_valid));
      end
      if (hs) begin
        check("req_avail", 32'(req_q.size() != 0), 32'd1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          check("req_write", 32'(MemReqWrite), 32'(r.wr));
          check("req_addr", MemReqAddr, r.addr);
          if (r.wr) check("req_data", MemReqData, r.data);
        end
        if (!first_hs_seen) begin
          first_hs_seen = 1;
          first_hs_addr = MemReqAddr;
        end
        if (!MemReqWrite) begin
          acc_addr = MemReqAddr;
          acc_cnt++;
        end
      end
      if (CacheWriteEn) begin
        check("cw_avail", 32'(cw_q.size() != 0), 32'd1);
        if (cw_q.size() != 0) begin
          w = cw_q.pop_front();
          check("cw_idx", 32'(CacheWordIndex), 32'(w.idx));
          check("cw_data", CacheWriteData, w.data);
        end
        cache_mem[CacheWordIndex] = CacheWriteData;
      end
      if (SpillDonePulse || FillDonePulse) begin
        check("done_both", 32'(SpillDonePulse && FillDonePulse), 32'd0);
        check("done_avail", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          check("done_kind", 32'(SpillDonePulse), 32'(d));
        end
        last_done_spill = SpillDonePulse;
        done_cnt++;
        done_cyc = cyc;
      end
      p_pend  = MemReqValid && !hs;
      p_addr  = MemReqAddr;
      p_data  = MemReqData;
      p_wr    = MemReqWrite;
      p_frz   = !clk_en;
      p_busy  = Busy;
      p_idx   = CacheWordIndex;
      p_valid = MemReqValid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    sync_rst = 1; clk_en = 1; SpillRequest = 0; FillRequest = 0;
    LineAddress = 32'h0; MemReqReady = 1;
    for (int i = 0; i < 8; i++) cache_mem[i] = 32'hC0DE_0000 + 32'(i);

    // Reset state and combinational stall during reset.
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_valid", 32'(MemReqValid), 32'd0);
    check("rst_readen", 32'(CacheReadEn), 32'd0);
    check("rst_wen", 32'(CacheWriteEn), 32'd0);
    check("rst_pulses", 32'({SpillDonePulse, FillDonePulse}), 32'd0);
    check("rst_idx", 32'(CacheWordIndex), 32'd0);
    FillRequest = 1; #1;
    check("rst_stall_req", 32'(StallOut), 32'd1);
    FillRequest = 0; #1;
    check("rst_stall_noreq", 32'(StallOut), 32'd0);
    @(posedge clk); #1;
    sync_rst = 0;

    // Spill of line 0x1000 with Ready high.
    @(posedge clk); #1;
    LineAddress = 32'h0000_1005;
    expect_spill(32'h1000);
    stall_low = 0;
    t0 = cyc;
    SpillRequest = 1;
    wait_done(1, 40);
    check("spill_latency", done_cyc - t0, 32'd9);
    check("spill_first_addr", first_hs_addr, 32'h0000_1000);
    check("spill_stall_low", 32'(stall_low), 32'd0);
    @(posedge clk); #1;
    SpillRequest = 0;
    @(negedge clk); #1;
    check("spill_idle_busy", 32'(Busy), 32'd0);
    check("spill_idle_valid", 32'(MemReqValid), 32'd0);
    check("spill_queue_left", 32'(req_q.size()), 32'd0);

    // Fill of line 0x2000, response one cycle after acceptance.
    @(posedge clk); #1;
    LineAddress = 32'h0000_2000;
    expect_fill(32'h2000);
    t0 = cyc;
    FillRequest = 1;
    wait_done(2, 60);
    check("fill_latency", done_cyc - t0, 32'd17);
    check("fill_word5", cache_mem[5], 32'h0000_00A5);
    @(posedge clk); #1;
    FillRequest = 0;

    // Backpressure on word 2 of a spill.
    @(posedge clk); #1;
    LineAddress = 32'h0000_1000;
    expect_spill(32'h1000);
    SpillRequest = 1;
    wait_req_idx(1'b1, 3'd1);
    @(posedge clk); #1;
    MemReqReady = 0;
    @(negedge clk); #1;
    check("bp_addr", MemReqAddr, 32'h0000_1002);
    check("bp_data", MemReqData, 32'h0000_00A2);
    repeat (3) @(posedge clk);
    #1;
    MemReqReady = 1;
    wait_done(3, 40);
    check("bp_queue_left", 32'(req_q.size()), 32'd0);
    @(posedge clk); #1;
    SpillRequest = 0;

    // Simultaneous requests: spill first, then fill while FillRequest stays high.
    @(posedge clk); #1;
    LineAddress = 32'h0000_3004;
    expect_spill(32'h3000);
    expect_fill(32'h3000);
    SpillRequest = 1;
    FillRequest  = 1;
    wait_done(4, 40);
    check("both_first_spill", 32'(last_done_spill), 32'd1);
    @(posedge clk); #1;
    SpillRequest = 0;
    wait_done(5, 60);
    check("both_second_fill", 32'(last_done_spill), 32'd0);
    @(posedge clk); #1;
    FillRequest = 0;

    // Reset while waiting for the word-4 response of a fill.
    @(posedge clk); #1;
    LineAddress = 32'h0000_4000;
    expect_fill(32'h4000);
    FillRequest = 1;
    wait_req_idx(1'b0, 3'd4);
    resp_en = 0;
    @(negedge clk); #1;
    check("rst_mid_wait", 32'(Busy && !MemReqValid && CacheWordIndex == 3'd4), 32'd1);
    sync_rst = 1;
    FillRequest = 0;
    req_q.delete();
    cw_q.delete();
    done_q.delete();
    @(posedge clk); #1;
    sync_rst = 0;
    resp_en  = 1;
    @(negedge clk); #1;
    check("rst_abort_busy", 32'(Busy), 32'd0);
    check("rst_late_resp", 32'(MemRespValid), 32'd1);
    check("rst_late_wen", 32'(CacheWriteEn), 32'd0);
    repeat (5) @(negedge clk);
    check("rst_no_done", 32'(done_cnt), 32'd5);

    // clk_en low for two cycles mid-spill.
    @(posedge clk); #1;
    LineAddress = 32'h0000_5000;
    expect_spill(32'h5000);
    SpillRequest = 1;
    wait_req_idx(1'b1, 3'd3);
    @(posedge clk); #1;
    clk_en = 0;
    @(negedge clk); #1;
    check("ce_spill_idx", 32'(CacheWordIndex), 32'd4);
    check("ce_spill_addr", MemReqAddr, 32'h0000_5004);
    repeat (2) @(posedge clk);
    #1;
    clk_en = 1;
    wait_done(6, 40);
    check("ce_spill_left", 32'(req_q.size()), 32'd0);
    @(posedge clk); #1;
    SpillRequest = 0;

    // clk_en low while a fill response is pending.
    @(posedge clk); #1;
    LineAddress = 32'h0000_6000;
    expect_fill(32'h6000);
    FillRequest = 1;
    wait_req_idx(1'b0, 3'd2);
    resp_en = 0;
    @(posedge clk); #1;
    clk_en = 0;
    repeat (2) @(posedge clk);
    #1;
    clk_en  = 1;
    resp_en = 1;
    wait_done(7, 60);
    check("ce_fill_word7", cache_mem[7], 32'h0000_00A7);
    check("ce_fill_left", 32'(cw_q.size()), 32'd0);
    @(posedge clk); #1;
    FillRequest = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
